csa_operand_loader: RTL and testbench

- Upstream feeder for the 4-operand, 4-bit carry_save_adder.
- Accepts a serial stream of 4-bit operands over a valid/ready handshake and groups them four at a time into a,b,c,d.
- Drives the CSA inputs from stable registers, captures the 6-bit result {cout,sum}, and presents it downstream with a valid/ready handshake.
- A short group can be flushed with in_last; the unused slots are zero-filled.

---
 rtl/csa_pkg.sv | 21 ++
 rtl/csa_result_checker.sv | 42 ++++
 rtl/csa_operand_loader.sv | 152 +++++++++++++++
 tb/tb_csa_operand_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// ============================================================================
// Module : csa_pkg
// Brief  : Shared widths and FSM state type for the CSA operand loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package csa_pkg;

    localparam int CSA_DATA_W = 4;
    localparam int CSA_RES_W  = 6;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } csa_ld_state_t;

endpackage

`default_nettype wire

// File: rtl/csa_result_checker.sv
// ============================================================================
// Module : csa_result_checker
// Brief  : Reference a+b+c+d compared against the CSA result; sticky error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csa_result_checker
    import csa_pkg::*;
#(
    parameter int DATA_W = CSA_DATA_W,
    parameter int RES_W  = CSA_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_d,
    input  logic [RES_W-1:0]  i_res,
    output logic              o_err
);

    logic [RES_W-1:0] w_ref;
    logic             r_err;

    assign w_ref = RES_W'(i_a) + RES_W'(i_b) + RES_W'(i_c) + RES_W'(i_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (i_en && (i_res != w_ref)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;

endmodule

`default_nettype wire

// File: rtl/csa_operand_loader.sv
// ============================================================================
// Module : csa_operand_loader
// Brief  : Groups a serial operand stream into a,b,c,d for the 4-operand CSA
//          and returns its result over a valid/ready handshake.
//          Optional result checker enabled by CSA_LOADER_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csa_operand_loader
    import csa_pkg::*;
#(
    parameter int DATA_W = CSA_DATA_W,
    parameter int RES_W  = CSA_RES_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] csa_a,
    output logic [DATA_W-1:0] csa_b,
    output logic [DATA_W-1:0] csa_c,
    output logic [DATA_W-1:0] csa_d,
    input  logic [RES_W-2:0]  csa_sum,
    input  logic              csa_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [2:0]        res_ops,
    output logic [CNT_W-1:0]  grp_cnt,
    output logic              chk_err
);

    csa_ld_state_t     r_state;
    csa_ld_state_t     w_next;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_op [4];
    logic [RES_W-1:0]  r_res_data;
    logic [2:0]        r_res_ops;
    logic              r_res_valid;
    logic [CNT_W-1:0]  r_grp_cnt;
    logic              w_accept;
    logic              w_close;
    logic              w_handshake;

    assign w_accept    = (r_state == FILL) && in_valid;
    assign w_close     = w_accept && ((r_cnt == 2'd3) || in_last);
    assign w_handshake = (r_state == HOLD) && r_res_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (w_close) begin
                    w_next = CALC;
                end
            end
            CALC: w_next = HOLD;
            HOLD: begin
                if (w_handshake) begin
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    // Slots above the closing beat are cleared so a short group sums to the
    // real operands only, regardless of what the slots held before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 2'd0;
            r_res_data  <= '0;
            r_res_ops   <= 3'd0;
            r_res_valid <= 1'b0;
            r_grp_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_op[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + 2'd1;
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == r_cnt) begin
                        r_op[i] <= in_data;
                    end else if (w_close && (2'(i) > r_cnt)) begin
                        r_op[i] <= '0;
                    end
                end
                if (w_close) begin
                    r_res_ops <= {1'b0, r_cnt} + 3'd1;
                end
            end
            if (r_state == CALC) begin
                r_res_data  <= {csa_cout, csa_sum};
                r_res_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_res_valid <= 1'b0;
                r_grp_cnt   <= r_grp_cnt + CNT_W'(1);
                r_cnt       <= 2'd0;
                for (int i = 0; i < 4; i++) begin
                    r_op[i] <= '0;
                end
            end
        end
    end

    assign csa_a     = r_op[0];
    assign csa_b     = r_op[1];
    assign csa_c     = r_op[2];
    assign csa_d     = r_op[3];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_ops   = r_res_ops;
    assign grp_cnt   = r_grp_cnt;

`ifdef CSA_LOADER_CHECK_EN
    csa_result_checker #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state == CALC),
        .i_a    (r_op[0]),
        .i_b    (r_op[1]),
        .i_c    (r_op[2]),
        .i_d    (r_op[3]),
        .i_res  ({csa_cout, csa_sum}),
        .o_err  (chk_err)
    );
`else
    assign chk_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_operand_loader.sv
// ============================================================================
// Module : tb_csa_operand_loader
// Brief  : Self-checking bench for csa_operand_loader with a behavioural CSA.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csa_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       in_last = 1'b0;
    logic [3:0] csa_a, csa_b, csa_c, csa_d;
    logic [4:0] csa_sum;
    logic       csa_cout;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_data;
    logic [2:0] res_ops;
    logic [7:0] grp_cnt;
    logic       chk_err;
    logic       csa_fault = 1'b0;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_grp  = 8'd0;
    logic       exp_err  = 1'b0;

    always #5 clk = ~clk;

    // Behavioural adder with an optional stuck-at-1 on sum bit 0.
    assign {csa_cout, csa_sum} = (6'(csa_a) + 6'(csa_b) + 6'(csa_c) + 6'(csa_d))
                                 | {5'd0, csa_fault};

    csa_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .csa_a     (csa_a),
        .csa_b     (csa_b),
        .csa_c     (csa_c),
        .csa_d     (csa_d),
        .csa_sum   (csa_sum),
        .csa_cout  (csa_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ops   (res_ops),
        .grp_cnt   (grp_cnt),
        .chk_err   (chk_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ops holds operand i in bits [4*i +: 4]; n real operands, the rest ignored.
    task automatic run_group(input logic [15:0] ops, input int n, input bit last4,
                             input int stall, input bit fault);
        int         t;
        int         sum;
        logic [5:0] exp_res;
        logic [15:0] exp_slots;
        sum       = 0;
        exp_slots = 16'd0;
        for (int i = 0; i < n; i++) begin
            sum += int'(ops[4*i +: 4]);
            exp_slots[15-4*i -: 4] = ops[4*i +: 4];
        end
        exp_res = 6'(sum) | {5'd0, fault};
`ifdef CSA_LOADER_CHECK_EN
        if (exp_res != 6'(sum)) exp_err = 1'b1;
`endif
        csa_fault = fault;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = ops[4*i +: 4];
            in_last  = (i == n-1) && ((n < 4) || last4);
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("calc_res_valid", 32'(res_valid), 32'd0);
        check("calc_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_data", 32'(res_data), 32'(exp_res));
        check("res_ops", 32'(res_ops), 32'(n));
        check("csa_ops", 32'({csa_a, csa_b, csa_c, csa_d}), 32'(exp_slots));
        check("chk_err", 32'(chk_err), 32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_res_data", 32'({res_valid, res_data}), 32'({1'b1, exp_res}));
            check("stall_csa_ops", 32'({csa_a, csa_b, csa_c, csa_d}), 32'(exp_slots));
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        check("hs_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        res_ready = 1'b0;
        exp_grp   = exp_grp + 8'd1;
        check("post_res_valid", 32'(res_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("grp_cnt", 32'(grp_cnt), 32'(exp_grp));
        check("post_csa_zero", 32'({csa_a, csa_b, csa_c, csa_d}), 32'd0);
        csa_fault = 1'b0;
    endtask

    initial begin
        logic [15:0] ops;
        int          n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", 32'({res_valid, res_data, res_ops, grp_cnt, chk_err}), 32'd0);
        check("rst_in_ready_post", 32'(in_ready), 32'd1);

        run_group({4'd9, 4'd7, 4'd5, 4'd3}, 4, 1'b0, 0, 1'b0);
        run_group({4'd15, 4'd15, 4'd15, 4'd15}, 4, 1'b1, 0, 1'b0);
        run_group({4'd0, 4'd0, 4'd4, 4'd6}, 2, 1'b0, 0, 1'b0);
        run_group({4'd8, 4'd2, 4'd11, 4'd1}, 4, 1'b0, 5, 1'b0);

        for (int g = 0; g < 30; g++) begin
            ops = 16'($urandom);
            n   = int'($urandom_range(1, 4));
            run_group(ops, n, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        // Asynchronous reset in the middle of a partially filled group.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'(13 - i);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", 32'({res_valid, res_data, res_ops, grp_cnt, chk_err}), 32'd0);
        check("arst_csa_zero", 32'({csa_a, csa_b, csa_c, csa_d}), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_grp = 8'd0;
        exp_err = 1'b0;
        run_group({4'd4, 4'd3, 4'd2, 4'd1}, 4, 1'b0, 0, 1'b0);

        for (int g = 0; g < 255; g++) begin
            run_group(16'($urandom), int'($urandom_range(1, 4)), 1'b0, 0, 1'b0);
        end
        check("grp_wrap", 32'(grp_cnt), 32'd0);

        run_group({4'd1, 4'd1, 4'd1, 4'd1}, 4, 1'b0, 0, 1'b1);
        run_group({4'd2, 4'd3, 4'd0, 4'd5}, 4, 1'b0, 1, 1'b0);
        check("chk_err_sticky", 32'(chk_err), 32'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
